// File: rtl/ps2pl_frame_rx.sv
// PS2PL command-stream receiver: parses the 16-byte SOP header of each frame,
// forwards the payload through one registered AXIS stage and flags framing errors.
module ps2pl_frame_rx #(
  parameter int MAX_LEN = 65536,
  parameter int DW      = 8
) (
  input  logic              pl_clk,
  input  logic              pl_rst,
  input  logic [16*DW-1:0]  s_axis_tdata,
  input  logic [15:0]       s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [16*DW-1:0]  m_axis_tdata,
  output logic [15:0]       m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              hdr_valid,
  output logic [15:0]       hdr_cmd,
  output logic [31:0]       hdr_len,
  output logic [63:0]       hdr_aux,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [15:0]       frame_ok_cnt,
  output logic [15:0]       frame_err_cnt
);

  // state   | meaning
  // IDLE    | next accepted beat is a header
  // PAYLOAD | forwarding beats, r_beats_left still expected
  // DRAIN   | discarding beats up to and including tlast
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DRAIN} state_t;

  localparam int BW = $clog2(MAX_LEN / 16 + 1);

  state_t          r_state;
  logic            r_rdy_en;
  logic [BW-1:0]   r_beats_left;
  logic [3:0]      r_rem;

  logic            w_s_fire;
  logic            w_hdr_fire;
  logic            w_pay_fire;
  logic            w_legal;
  logic [31:0]     w_len;
  logic            w_pay_last;
  logic [1:0]      w_hdr_code;
  logic [1:0]      w_pay_code;
  logic [1:0]      w_err_code;
  logic            w_ok_fire;
  logic [15:0]     w_last_keep;

  function automatic logic f_legal(input logic [15:0] c);
    case (c) inside
      [16'h00A0:16'h00A3], [16'h01A0:16'h01A3], 16'h00A8,
      [16'h00B0:16'h00B2], [16'h01B0:16'h01B1], [16'h00B8:16'h00BB],
      16'h01B8, 16'h01B9, 16'h01BB, [16'h00C0:16'h00C5]: f_legal = 1'b1;
      default: f_legal = 1'b0;
    endcase
  endfunction

  // Back-pressure only matters while payload is being forwarded.
  assign s_axis_tready = r_rdy_en &&
                         ((r_state != S_PAYLOAD) || !m_axis_tvalid || m_axis_tready);

  assign w_s_fire   = s_axis_tvalid && s_axis_tready;
  assign w_hdr_fire = w_s_fire && (r_state == S_IDLE);
  assign w_pay_fire = w_s_fire && (r_state == S_PAYLOAD);
  assign w_len      = s_axis_tdata[63:32];
  assign w_legal    = f_legal(s_axis_tdata[15:0]);
  assign w_pay_last = (r_beats_left == BW'(1));

  always_comb begin
    w_hdr_code = 2'd0;
    if (!w_legal)
      w_hdr_code = 2'd1;
    else if (w_len > 32'(MAX_LEN))
      w_hdr_code = 2'd3;
    else if (w_len == 32'd0)
      w_hdr_code = s_axis_tlast ? 2'd0 : 2'd3;
    else if (s_axis_tlast)
      w_hdr_code = 2'd2;
  end

  always_comb begin
    w_pay_code = 2'd0;
    if (w_pay_last)
      w_pay_code = s_axis_tlast ? 2'd0 : 2'd3;
    else if (s_axis_tlast)
      w_pay_code = 2'd2;
  end

  always_comb begin
    w_last_keep = 16'h0000;
    for (int k = 0; k < 16; k++)
      w_last_keep[k] = (r_rem == 4'd0) || (4'(k) < r_rem);
  end

  assign w_err_code = w_hdr_fire ? w_hdr_code : (w_pay_fire ? w_pay_code : 2'd0);
  assign w_ok_fire  = (w_hdr_fire && w_legal && (w_len == 32'd0) && s_axis_tlast) ||
                      (w_pay_fire && w_pay_last && s_axis_tlast);

  always_ff @(posedge pl_clk or posedge pl_rst) begin
    if (pl_rst) begin
      r_state       <= S_IDLE;
      r_rdy_en      <= 1'b0;
      r_beats_left  <= '0;
      r_rem         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      hdr_valid     <= 1'b0;
      hdr_cmd       <= '0;
      hdr_len       <= '0;
      hdr_aux       <= '0;
      err_valid     <= 1'b0;
      err_code      <= '0;
      frame_ok_cnt  <= '0;
      frame_err_cnt <= '0;
    end else begin
      r_rdy_en  <= 1'b1;
      hdr_valid <= 1'b0;
      err_valid <= (w_err_code != 2'd0);
      if (w_err_code != 2'd0) begin
        err_code <= w_err_code;
        if (frame_err_cnt != 16'hFFFF)
          frame_err_cnt <= frame_err_cnt + 16'd1;
      end
      if (w_ok_fire && (frame_ok_cnt != 16'hFFFF))
        frame_ok_cnt <= frame_ok_cnt + 16'd1;

      if (m_axis_tready)
        m_axis_tvalid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_hdr_fire) begin
            hdr_cmd   <= s_axis_tdata[15:0];
            hdr_len   <= w_len;
            hdr_aux   <= s_axis_tdata[127:64];
            hdr_valid <= w_legal;
            if (w_hdr_code != 2'd0) begin
              r_state <= s_axis_tlast ? S_IDLE : S_DRAIN;
            end else if (w_len != 32'd0) begin
              r_beats_left <= BW'((w_len + 32'd15) >> 4);
              r_rem        <= w_len[3:0];
              r_state      <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_pay_fire) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= w_pay_last ? w_last_keep : s_axis_tkeep;
            m_axis_tlast  <= w_pay_last || s_axis_tlast;
            m_axis_tuser  <= (w_pay_code != 2'd0);
            m_axis_tvalid <= 1'b1;
            r_beats_left  <= r_beats_left - BW'(1);
            if (w_pay_last)
              r_state <= s_axis_tlast ? S_IDLE : S_DRAIN;
            else if (s_axis_tlast)
              r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (w_s_fire && s_axis_tlast)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2pl_frame_rx.sv
// Scoreboard bench for ps2pl_frame_rx: directed frames push expected beats,
// headers and errors into queues that a negedge monitor pops and compares.
module tb_ps2pl_frame_rx;

  logic          pl_clk = 1'b0;
  logic          pl_rst = 1'b1;
  logic [127:0]  s_axis_tdata = '0;
  logic [15:0]   s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [127:0]  m_axis_tdata;
  logic [15:0]   m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          hdr_valid;
  logic [15:0]   hdr_cmd;
  logic [31:0]   hdr_len;
  logic [63:0]   hdr_aux;
  logic          err_valid;
  logic [1:0]    err_code;
  logic [15:0]   frame_ok_cnt;
  logic [15:0]   frame_err_cnt;

  ps2pl_frame_rx dut (
    .pl_clk(pl_clk), .pl_rst(pl_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .hdr_valid(hdr_valid), .hdr_cmd(hdr_cmd), .hdr_len(hdr_len), .hdr_aux(hdr_aux),
    .err_valid(err_valid), .err_code(err_code),
    .frame_ok_cnt(frame_ok_cnt), .frame_err_cnt(frame_err_cnt)
  );

  always #5 pl_clk = ~pl_clk;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
    logic         u;
  } beat_t;

  typedef struct packed {
    logic [15:0] c;
    logic [31:0] l;
    logic [63:0] a;
  } hdr_t;

  beat_t       q_beat[$];
  hdr_t        q_hdr[$];
  logic [1:0]  q_err[$];

  int n_checks = 0;
  int n_errors = 0;
  int fid = 0;
  bit tgl_mode = 1'b0;
  bit bp_on = 1'b0;
  bit bp_chk = 1'b0;

  function automatic logic [127:0] pat(input int f, input int b);
    return {4{ {8'(f), 8'h5A, 16'(b)} }};
  endfunction

  // Downstream ready: held high, or toggling 1010... during the back-pressure frame.
  initial begin
    forever begin
      @(posedge pl_clk);
      #1;
      m_axis_tready = tgl_mode ? ~m_axis_tready : 1'b1;
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data = '0;
  initial begin
    beat_t b;
    hdr_t  h;
    logic [1:0] e;
    forever begin
      @(negedge pl_clk);
      if (!pl_rst) begin
        if (prev_stall) begin
          n_checks++;
          if (!m_axis_tvalid || (m_axis_tdata != prev_data)) begin
            n_errors++;
            $display("FAIL stall_hold: tvalid=%0b data=%h required tvalid=1 data=%h",
                     m_axis_tvalid, m_axis_tdata, prev_data);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;

        if (bp_chk && m_axis_tvalid && !m_axis_tready) begin
          n_checks++;
          if (s_axis_tready) begin
            n_errors++;
            $display("FAIL bp_ready: s_axis_tready=1 required 0 while output full");
          end
        end

        if (m_axis_tvalid && m_axis_tready) begin
          n_checks++;
          if (q_beat.size() == 0) begin
            n_errors++;
            $display("FAIL beat_extra: unexpected beat data=%h last=%0b", m_axis_tdata, m_axis_tlast);
          end else begin
            b = q_beat.pop_front();
            if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} != b) begin
              n_errors++;
              $display("FAIL beat: got d=%h k=%h l=%0b u=%0b required d=%h k=%h l=%0b u=%0b",
                       m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, b.d, b.k, b.l, b.u);
            end
          end
        end

        if (hdr_valid) begin
          n_checks++;
          if (q_hdr.size() == 0) begin
            n_errors++;
            $display("FAIL hdr_extra: unexpected hdr_valid cmd=%h len=%0d", hdr_cmd, hdr_len);
          end else begin
            h = q_hdr.pop_front();
            if ({hdr_cmd, hdr_len, hdr_aux} != h) begin
              n_errors++;
              $display("FAIL hdr: got cmd=%h len=%0d aux=%h required cmd=%h len=%0d aux=%h",
                       hdr_cmd, hdr_len, hdr_aux, h.c, h.l, h.a);
            end
          end
        end

        if (err_valid) begin
          n_checks++;
          if (q_err.size() == 0) begin
            n_errors++;
            $display("FAIL err_extra: unexpected err_valid code=%0d", err_code);
          end else begin
            e = q_err.pop_front();
            if (err_code != e) begin
              n_errors++;
              $display("FAIL err_code: got %0d required %0d", err_code, e);
            end
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
    bit rdy;
    int n;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 1000) begin
      @(negedge pl_clk);
      rdy = s_axis_tready;
      @(posedge pl_clk);
      #1;
      n++;
    end
    if (!rdy) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: s_axis_tready=0 required 1 within 1000 cycles");
    end
  endtask

  // nb payload beats are sent after the header (tlast on the last one, or on
  // the header when nb==0); fwd beats are expected out, the last one with lkeep/luser.
  task automatic frame(input logic [15:0] cmd, input logic [31:0] len, input int nb,
                       input bit exp_hv, input logic [1:0] exp_err, input int fwd,
                       input logic [15:0] lkeep, input bit luser);
    logic [63:0] aux;
    beat_t b;
    fid++;
    aux = {16'hC0DE, 16'(fid), cmd, 16'hBEEF};
    if (exp_hv) q_hdr.push_back({cmd, len, aux});
    if (exp_err != 2'd0) q_err.push_back(exp_err);
    for (int i = 0; i < fwd; i++) begin
      b.d = pat(fid, i);
      b.k = (i == fwd - 1) ? lkeep : 16'hFFFF;
      b.l = (i == fwd - 1);
      b.u = (i == fwd - 1) ? luser : 1'b0;
      q_beat.push_back(b);
    end
    send_beat({aux, len, 16'h0000, cmd}, 16'hFFFF, nb == 0);
    if (bp_on) bp_chk = 1'b1;
    for (int i = 0; i < nb; i++)
      send_beat(pat(fid, i), 16'hFFFF, i == nb - 1);
    bp_chk = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge pl_clk);
    @(negedge pl_clk);
    check_val("rst_tready", 64'(s_axis_tready), 64'd0);
    check_val("rst_outputs", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, hdr_valid, err_valid}), 64'd0);
    check_val("rst_counters", 64'({frame_ok_cnt, frame_err_cnt}), 64'd0);
    check_val("rst_hdr", 64'({hdr_cmd, hdr_len}), 64'd0);
    @(posedge pl_clk);
    #1;
    pl_rst = 1'b0;
    @(negedge pl_clk);
    check_val("tready_before_edge", 64'(s_axis_tready), 64'd0);
    @(negedge pl_clk);
    check_val("tready_after_edge", 64'(s_axis_tready), 64'd1);
    @(posedge pl_clk);
    #1;

    frame(16'h00A0, 32'd32,    2,   1'b1, 2'd0, 2,   16'hFFFF, 1'b0);
    frame(16'h00A8, 32'd2908,  182, 1'b1, 2'd0, 182, 16'h0FFF, 1'b0);
    frame(16'h00B0, 32'd48,    2,   1'b1, 2'd2, 2,   16'hFFFF, 1'b1);
    frame(16'h00C5, 32'd16,    3,   1'b1, 2'd3, 1,   16'hFFFF, 1'b1);
    frame(16'h01BB, 32'd20,    2,   1'b1, 2'd0, 2,   16'h000F, 1'b0);
    frame(16'h1234, 32'd64,    4,   1'b0, 2'd1, 0,   16'h0000, 1'b0);
    tgl_mode = 1'b1;
    bp_on    = 1'b1;
    frame(16'h00C0, 32'd5816,  364, 1'b1, 2'd0, 364, 16'h00FF, 1'b0);
    bp_on    = 1'b0;
    tgl_mode = 1'b0;
    frame(16'h01B9, 32'd0,     0,   1'b1, 2'd0, 0,   16'h0000, 1'b0);
    frame(16'h00A1, 32'd0,     1,   1'b1, 2'd3, 0,   16'h0000, 1'b0);
    frame(16'h00A2, 32'd65537, 2,   1'b1, 2'd3, 0,   16'h0000, 1'b0);
    frame(16'h00B1, 32'd65536, 4096, 1'b1, 2'd0, 4096, 16'hFFFF, 1'b0);
    frame(16'h00BA, 32'd16,    0,   1'b1, 2'd2, 0,   16'h0000, 1'b0);
    frame(16'h01BA, 32'd16,    0,   1'b0, 2'd1, 0,   16'h0000, 1'b0);
    frame(16'h00A4, 32'd16,    1,   1'b0, 2'd1, 0,   16'h0000, 1'b0);
    frame(16'h01A3, 32'd16,    1,   1'b1, 2'd0, 1,   16'hFFFF, 1'b0);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;

    n = 0;
    while ((q_beat.size() + q_hdr.size() + q_err.size()) != 0 && n < 200) begin
      @(posedge pl_clk);
      n++;
    end
    repeat (4) @(posedge pl_clk);
    @(negedge pl_clk);
    check_val("beats_outstanding", 64'(q_beat.size()), 64'd0);
    check_val("hdrs_outstanding", 64'(q_hdr.size()), 64'd0);
    check_val("errs_outstanding", 64'(q_err.size()), 64'd0);
    check_val("frame_ok_cnt", 64'(frame_ok_cnt), 64'd7);
    check_val("frame_err_cnt", 64'(frame_err_cnt), 64'd8);
    check_val("idle_tready", 64'(s_axis_tready), 64'd1);
    check_val("final_hdr_cmd", 64'(hdr_cmd), 64'h01A3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
